mem_burst_master: RTL and testbench

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

---
 rtl/mem_burst_master.sv | 153 +++++++++++++++
 tb/tb_mem_burst_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_master.sv
// Burst master: turns one command into 1..16 sequential word accesses on a synchronous single-port memory.
// Latency: writes take 1 beat/cycle after the accept cycle; reads take 2 cycles/beat (address cycle + data cycle).
// Backpressure: wr_valid low stalls a write beat; rd_ready low holds rd_data stable by holding mem_addr.
module mem_burst_master #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 512,
    localparam int ADDR_W   = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    // Command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [3:0]        cmd_len,

    // Write-beat stream
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,

    // Read-beat stream
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,

    output logic              busy,

    // Memory side (synchronous single-port RAM)
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_READ_ADDR = 2'd2,
        S_READ_DATA = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Burst context: current word address and beats still to go after the current one.
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_beats;

    logic              w_accept;
    logic              w_beat_done;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_addr_inc;

    // The current beat is the final one once no further beats remain.
    assign w_last_beat = (r_beats == 4'd0);

    // Explicit wrap so a non-power-of-two depth still rolls over at the top word.
    assign w_addr_inc = (r_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : (r_addr + ADDR_W'(1));

    // State register; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context: load on accept, advance address and count on every completed beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_beats <= '0;
        end else if (w_accept) begin
            r_addr  <= cmd_addr;
            r_beats <= cmd_len;
        end else if (w_beat_done) begin
            r_addr <= w_addr_inc;
            // Stop at zero so the count reads 0 between bursts.
            if (!w_last_beat) begin
                r_beats <= r_beats - 4'd1;
            end
        end
    end

    // Next-state and all outputs; everything is zero unless the current state drives it.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_beat_done = 1'b0;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        wr_ready    = 1'b0;
        rd_valid    = 1'b0;
        rd_data     = '0;
        rd_last     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = cmd_we ? S_WRITE : S_READ_ADDR;
                end
            end

            S_WRITE: begin
                // Write strobe follows wr_valid directly so a stalled beat never touches memory.
                wr_ready  = 1'b1;
                mem_we    = wr_valid;
                mem_addr  = r_addr;
                mem_wdata = wr_data;
                if (wr_valid) begin
                    w_beat_done = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_READ_ADDR: begin
                // Present the address; the RAM returns the word on the next cycle.
                mem_addr    = r_addr;
                w_state_nxt = S_READ_DATA;
            end

            S_READ_DATA: begin
                // Keeping mem_addr on the same word re-reads it every edge, so rd_data holds under backpressure.
                rd_valid = 1'b1;
                rd_data  = mem_rdata;
                rd_last  = w_last_beat;
                mem_addr = r_addr;
                if (rd_ready) begin
                    w_beat_done = 1'b1;
                    w_state_nxt = w_last_beat ? S_IDLE : S_READ_ADDR;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: table of bursts plus hand-written backpressure, command-noise, long-burst and reset cases.
// Expected memory writes and read beats are queued when stimulus is driven and checked by negedge monitors.
// The memory model seeds mem[i]=i and behaves as a synchronous single-port RAM.
module tb_mem_burst_master;

    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_burst_master #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port memory, seeded with mem[i]=i on the first edge.
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    bit                seeded;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'(i);
            mem_rdata <= '0;
            seeded    <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else begin
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] dat; } wexp_t;
    typedef struct { logic [DATA_W-1:0] dat; logic last; } rexp_t;
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [4:0]        wpat;
        logic [4:0]        rpat;
        logic [3:0][31:0]  dat;
    } vec_t;

    wexp_t             wq [$];
    rexp_t             rq [$];
    logic [DATA_W-1:0] model [MEM_DEPTH];
    logic [DATA_W-1:0] dbuf [16];
    logic [DATA_W-1:0] ebuf [16];
    vec_t              tbl [9];
    int                n_cmp;
    int                n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every memory write must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: got write addr %0d data %h, expected none at %0t", mem_addr, mem_wdata, $time);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.dat);
            end
        end
    end

    // Read monitor: every completed read beat must match the next queued expectation.
    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_unexpected: got beat %h, expected none at %0t", rd_data, $time);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("rd_data", rd_data, e.dat);
                chk("rd_last", 32'(rd_last), 32'(e.last));
            end
        end
    end

    function automatic vec_t mk(input logic we, input int a, input int l, input logic [4:0] wp,
                                input logic [4:0] rp, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.we = we; v.addr = ADDR_W'(a); v.len = 4'(l); v.wpat = wp; v.rpat = rp;
        v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a, input int k);
        return ADDR_W'((int'(a) + k) % MEM_DEPTH);
    endfunction

    // Present a command in IDLE; it must be taken on the first edge.
    task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // After a burst: back in IDLE the very next cycle with nothing outstanding.
    task automatic post();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [3:0] l, input logic [4:0] wpat, input logic noise);
        int k;
        int cyc;
        logic rdy;
        issue(1'b1, a, l);
        for (int j = 0; j <= int'(l); j++) begin
            wq.push_back('{wrap(a, j), dbuf[j]});
            model[wrap(a, j)] = dbuf[j];
        end
        k = 0; cyc = 0;
        while (k <= int'(l) && cyc < 100) begin
            wr_valid  = wpat[cyc % 5];
            wr_data   = dbuf[k];
            cmd_valid = noise && (k != int'(l));
            cmd_we = 1'b0; cmd_addr = 9'd50; cmd_len = 4'd9;
            @(negedge clk);
            chk("busy_in_write", 32'(busy), 32'd1);
            chk("rd_valid_in_write", 32'(rd_valid), 32'd0);
            rdy = wr_ready;
            @(posedge clk); #1;
            if (wr_valid && rdy) k++;
            cyc++;
        end
        wr_valid = 1'b0; wr_data = '0; cmd_valid = 1'b0;
        chk("wr_beats_done", 32'(k), 32'(int'(l) + 1));
        post();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [3:0] l, input logic [4:0] rpat, input logic noise);
        int k;
        int cyc;
        logic v;
        issue(1'b0, a, l);
        for (int j = 0; j <= int'(l); j++) rq.push_back('{ebuf[j], (j == int'(l))});
        k = 0; cyc = 0;
        while (k <= int'(l) && cyc < 200) begin
            rd_ready  = rpat[cyc % 5];
            cmd_valid = noise && (k != int'(l));
            cmd_we = 1'b1; cmd_addr = 9'd77; cmd_len = 4'd2;
            @(negedge clk);
            chk("busy_in_read", 32'(busy), 32'd1);
            chk("wr_ready_in_read", 32'(wr_ready), 32'd0);
            v = rd_valid;
            @(posedge clk); #1;
            if (v && rd_ready) k++;
            cyc++;
        end
        rd_ready = 1'b0; cmd_valid = 1'b0;
        chk("rd_beats_done", 32'(k), 32'(int'(l) + 1));
        post();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) model[i] = 32'(i);

        tbl[0] = mk(1'b1,  10, 3, 5'b11111, 5'b11111, 32'hA,  32'hB,  32'hC,  32'hD);
        tbl[1] = mk(1'b0,  10, 3, 5'b11111, 5'b11111, 32'hA,  32'hB,  32'hC,  32'hD);
        tbl[2] = mk(1'b1, 510, 3, 5'b11111, 5'b11111, 32'd1,  32'd2,  32'd3,  32'd4);
        tbl[3] = mk(1'b0, 510, 3, 5'b11111, 5'b11111, 32'd1,  32'd2,  32'd3,  32'd4);
        tbl[4] = mk(1'b1, 100, 2, 5'b10101, 5'b11111, 32'h11, 32'h22, 32'h33, 32'h0);
        tbl[5] = mk(1'b0, 100, 2, 5'b11111, 5'b01101, 32'h11, 32'h22, 32'h33, 32'h0);
        tbl[6] = mk(1'b0, 511, 1, 5'b11111, 5'b00110, 32'd2,  32'd3,  32'h0,  32'h0);
        tbl[7] = mk(1'b1,   0, 0, 5'b11111, 5'b11111, 32'hDEAD, 32'h0, 32'h0, 32'h0);
        tbl[8] = mk(1'b0,   0, 0, 5'b11111, 5'b11111, 32'hDEAD, 32'h0, 32'h0, 32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of bursts, first one issued on the first edge after reset release
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 4; j++) begin
                dbuf[j] = tbl[i].dat[j];
                ebuf[j] = tbl[i].dat[j];
            end
            if (tbl[i].we) do_write(tbl[i].addr, tbl[i].len, tbl[i].wpat, 1'b0);
            else           do_read(tbl[i].addr, tbl[i].len, tbl[i].rpat, 1'b0);
        end

        // Read backpressure: beat held stable for three cycles, then the next beat follows
        issue(1'b0, 9'd5, 4'd1);
        rq.push_back('{32'd5, 1'b0});
        rq.push_back('{32'd6, 1'b1});
        rd_ready = 1'b0;
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rd_valid", 32'(rd_valid), 32'd1);
            chk("bp_rd_data", rd_data, 32'd5);
            chk("bp_mem_addr", 32'(mem_addr), 32'd5);
            chk("bp_rd_last", 32'(rd_last), 32'd0);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        cyc = 0;
        while (rq.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd_ready = 1'b0;
        chk("bp_beats_done", 32'(rq.size()), 32'd0);
        post();

        // Commands presented while busy must be ignored
        for (int j = 0; j < 4; j++) dbuf[j] = 32'h300 + 32'(j);
        do_write(9'd300, 4'd3, 5'b11011, 1'b1);
        for (int j = 0; j < 4; j++) ebuf[j] = model[wrap(9'd300, j)];
        do_read(9'd300, 4'd3, 5'b11111, 1'b1);

        // Maximum burst length, crossing no boundary
        for (int j = 0; j < 16; j++) dbuf[j] = 32'h1000 + 32'(j);
        do_write(9'd400, 4'd15, 5'b11111, 1'b0);
        for (int j = 0; j < 16; j++) ebuf[j] = model[wrap(9'd400, j)];
        do_read(9'd400, 4'd15, 5'b11011, 1'b0);

        // Reset during the third beat of an 8-beat write
        for (int j = 0; j < 8; j++) dbuf[j] = 32'h5000 + 32'(j);
        issue(1'b1, 9'd200, 4'd7);
        wq.push_back('{9'd200, dbuf[0]});
        wq.push_back('{9'd201, dbuf[1]});
        model[200] = dbuf[0];
        model[201] = dbuf[1];
        wr_valid = 1'b1; wr_data = dbuf[0];
        @(posedge clk); #1;
        wr_data = dbuf[1];
        @(posedge clk); #1;
        wr_data = dbuf[2];
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wq", 32'(wq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_mem_we", 32'(mem_we), 32'd0);
            chk("post_rst_wr_ready", 32'(wr_ready), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        ebuf[0] = model[0];
        do_read(9'd0, 4'd0, 5'b11111, 1'b0);
        dbuf[0] = model[202];
        ebuf[0] = model[202];
        do_read(9'd202, 4'd0, 5'b11111, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
